// File: rtl/alu_iterative.sv
// alu_iterative: handshaked ALU with an iterative shift-add multiplier.
// Defining ALU_DIV_EN adds the restoring divider (DIVU/REMU). Without it, those opcodes are illegal.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Negative,
  output logic             OverFlow,
  output logic             Carry,
  output logic             Illegal
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [LW:0] CNT_ONE = (LW+1)'(1);
  localparam logic [LW:0] CNT_W = (LW+1)'(WIDTH);
`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif
  state_t             state_q, state_d;
  logic [LW:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx, mul_nx;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               op_hi_q, op_hi_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, carry_q, carry_d, ill_q, ill_d;
  logic               accept, iter, is_sub, is_addsub, is_mul, is_div, sc_ill, upd, c_new, v_new, ill_new;
  logic [WIDTH-1:0]   bb, sc_res, res_new;
  logic [WIDTH:0]     sum, msum;
  logic [LW-1:0]      shamt;
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = state_q == DONE;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;
  assign OverFlow  = ovf_q;
  assign Carry     = carry_q;
  assign Illegal   = ill_q;
  assign shamt     = B[LW-1:0];
  assign is_sub    = ALUControl == 4'b0001;
  assign is_addsub = ALUControl[3:1] == 3'b000;
  assign is_mul    = ALUControl[3:1] == 3'b101;
  assign bb        = is_sub ? ~B : B;
  assign sum       = {1'b0, A} + {1'b0, bb} + {{WIDTH{1'b0}}, is_sub};
  // Multiplier lives in the low half of prod and shifts out as the product shifts in.
  assign msum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? opnd_q : '0};
  assign mul_nx    = {msum, prod_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     rem_ext, diff;
  logic [2*WIDTH-1:0] div_nx;
  logic               ge;
  assign is_div  = ALUControl[3:1] == 3'b110;
  assign sc_ill  = ALUControl[3:1] == 3'b111;
  // prod holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign rem_ext = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign diff    = rem_ext - {1'b0, opnd_q};
  assign ge      = ~diff[WIDTH];
  assign div_nx  = {ge ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0], prod_q[WIDTH-2:0], ge};
  assign iter    = (state_q == MUL) | (state_q == DIV);
  assign prod_nx = (state_q == DIV) ? div_nx : mul_nx;
`else
  assign is_div  = 1'b0;
  assign sc_ill  = ALUControl >= 4'hC;
  assign iter    = state_q == MUL;
  assign prod_nx = mul_nx;
`endif
  always_comb begin
    sc_res = '0;
    case (ALUControl)
      4'h0, 4'h1: sc_res = sum[WIDTH-1:0];
      4'h2:       sc_res = A & B;
      4'h3:       sc_res = A | B;
      4'h4:       sc_res = A ^ B;
      4'h5:       sc_res = WIDTH'($signed(A) < $signed(B));
      4'h6:       sc_res = WIDTH'(A < B);
      4'h7:       sc_res = A << shamt;
      4'h8:       sc_res = A >> shamt;
      4'h9:       sc_res = $signed(A) >>> shamt;
`ifdef ALU_DIV_EN
      4'hC:       sc_res = '1;
      4'hD:       sc_res = A;
`endif
      default:    sc_res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    op_hi_d = op_hi_q;
    upd     = 1'b0;
    res_new = '0;
    c_new   = 1'b0;
    v_new   = 1'b0;
    ill_new = 1'b0;
    if ((state_q == DONE) & out_ready) state_d = IDLE;
    if (iter) begin
      prod_d = prod_nx;
      cnt_d  = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = DONE;
        upd     = 1'b1;
        res_new = op_hi_q ? prod_nx[2*WIDTH-1:WIDTH] : prod_nx[WIDTH-1:0];
      end
    end
    if (accept) begin
      op_hi_d = ALUControl[0];
      cnt_d   = CNT_W;
      if (is_mul) begin
        state_d = MUL;
        opnd_d  = A;
        prod_d  = {{WIDTH{1'b0}}, B};
`ifdef ALU_DIV_EN
      end else if (is_div & (B != '0)) begin
        state_d = DIV;
        opnd_d  = B;
        prod_d  = {{WIDTH{1'b0}}, A};
`endif
      end else begin
        state_d = DONE;
        upd     = 1'b1;
        res_new = sc_res;
        c_new   = is_addsub & sum[WIDTH];
        v_new   = is_addsub & (A[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
        ill_new = sc_ill;
      end
    end
    result_d = upd ? res_new : result_q;
    zero_d   = upd ? (res_new == '0) : zero_q;
    neg_d    = upd ? res_new[WIDTH-1] : neg_q;
    carry_d  = upd ? c_new : carry_q;
    ovf_d    = upd ? v_new : ovf_q;
    ill_d    = upd ? ill_new : ill_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_hi_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      op_hi_q  <= op_hi_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      ill_q    <= ill_d;
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: random and directed checks of alu_iterative against an arithmetic reference model.
module tb_alu_iterative;
  logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic [3:0]  ctl = 0;
  logic        in_ready, out_valid, zero, neg, ovf, carry, ill;
  logic [31:0] result;
  logic [4:0]  flags;
  int          n_chk = 0, n_pass = 0;
  assign flags = {ill, carry, ovf, neg, zero};
  always #5 clk = ~clk;
  alu_iterative #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .ALUControl(ctl), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .Zero(zero), .Negative(neg), .OverFlow(ovf), .Carry(carry), .Illegal(ill)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  // flags packed as {illegal, carry, overflow, negative, zero}
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [4:0] f, output int lat);
    logic [63:0] p;
    longint      s;
    logic        c, v, il;
    r = '0; c = 0; v = 0; il = 0; lat = 1; s = 0;
    p = 64'(x) * 64'(y);
    case (op)
      4'd0: begin r = x + y; s = longint'($signed(x)) + longint'($signed(y)); c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF; v = s != longint'($signed(r)); end
      4'd1: begin r = x - y; s = longint'($signed(x)) - longint'($signed(y)); c = x >= y; v = s != longint'($signed(r)); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd6: r = (x < y) ? 1 : 0;
      4'd7: r = x << y[4:0];
      4'd8: r = x >> y[4:0];
      4'd9: r = $signed(x) >>> y[4:0];
      4'd10: begin r = p[31:0]; lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
`ifdef ALU_DIV_EN
      4'd12, 4'd13: begin
        if (y == 0) r = (op == 4'd12) ? 32'hFFFF_FFFF : x;
        else begin r = (op == 4'd12) ? x / y : x % y; lat = 33; end
      end
`endif
      default: il = 1;
    endcase
    f = {il, c, v, r[31], r == 0};
  endfunction
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit rel);
    logic [31:0] er;
    logic [4:0]  ef;
    int          el, lat;
    bit          busy_ok;
    model(op, x, y, er, ef, el);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    ctl = op; a = x; b = y; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0; a = $urandom; b = $urandom;
    lat = 1; busy_ok = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 0;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, el);
    check($sformatf("result op%0d %h,%h", op, x, y), result, er);
    check($sformatf("flags op%0d %h,%h", op, x, y), flags, ef);
    check("busy_in_ready", busy_ok, 1);
    if (rel) out_ready = 1;
  endtask
  initial begin
    logic [31:0] er;
    logic [4:0]  ef;
    int          el;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    @(negedge clk) rst = 1;
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1);
    check("add_ovf_res", result, 32'h8000_0000);
    check("add_ovf_flags", flags, 5'b00110);
    run_op(4'd1, 32'd5, 32'd5, 1);
    check("sub_eq_flags", flags, 5'b01001);
    run_op(4'd6, 32'd1, 32'hFFFF_FFFF, 1);
    check("sltu_res", result, 1);
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("mul_res", result, 32'h1);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("mulhu_res", result, 32'hFFFF_FFFE);
    run_op(4'd12, 32'd100, 32'd7, 1);
`ifdef ALU_DIV_EN
    check("divu_res", result, 14);
    run_op(4'd13, 32'd100, 32'd7, 1);
    check("remu_res", result, 2);
    run_op(4'd12, 32'd9, 32'd0, 1);
    check("divu0_res", result, 32'hFFFF_FFFF);
    run_op(4'd13, 32'd9, 32'd0, 1);
    check("remu0_res", result, 9);
`else
    check("divu_illegal", {result, ill}, {32'h0, 1'b1});
`endif
    // backpressure then same-cycle handoff to the next op
    run_op(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_res", result, 32'h0F0F_F0F0);
      check("bp_in_ready", in_ready, 0);
    end
    ctl = 4'd0; a = 2; b = 3; in_valid = 1; out_ready = 1;
    #1 check("bp_in_ready_hi", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    check("bp_add_valid", out_valid, 1);
    check("bp_add_res", result, 5);
    // back-to-back single-cycle ops
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check("tp_valid", out_valid, 1);
        check("tp_res", result, er);
        check("tp_flags", flags, ef);
      end
      if (i < 8) begin
        ctl = 4'($urandom_range(0, 9)); a = $urandom; b = $urandom;
        model(ctl, a, b, er, ef, el);
        in_valid = 1;
      end else in_valid = 0;
      @(negedge clk);
    end
    // reset in the middle of a multiply
    ctl = 4'd10; a = $urandom; b = $urandom; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    rst = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    @(negedge clk) rst = 1;
    run_op(4'd0, 32'd1, 32'd1, 1);
    check("post_rst_add", result, 2);
    repeat (40) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(4'($urandom_range(0, 15)), x, y, 1);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
